// File: rtl/plru_array.sv
// Per-set tree pseudo-LRU state for an N-way set-associative cache.
// Combinational victim lookup, touch update with optional bypass, and a sequenced clear sweep.
module plru_array #(
    parameter int unsigned s_index = 3,
    parameter int unsigned s_way   = 2,
    parameter bit          BYPASS  = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [s_index-1:0]        rindex,
    output logic [s_way-1:0]          victim,
    output logic [(2**s_way)-2:0]     plru_out,
    input  logic                      touch,
    input  logic [s_index-1:0]        windex,
    input  logic [s_way-1:0]          tway,
    input  logic                      clear_req,
    output logic                      busy
);

    localparam int unsigned NumSets = 2 ** s_index;
    localparam int unsigned Ways    = 2 ** s_way;
    localparam int unsigned TreeW   = Ways - 1;

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e               state_q, state_d;
    logic [s_index-1:0]   cnt_q, cnt_d;
    logic [TreeW-1:0]     mem_q [NumSets];

    logic                 touch_en;
    logic [TreeW-1:0]     wr_tree;
    logic [TreeW-1:0]     rd_tree;

    // Mark every node on the path to w as pointing away from w.
    function automatic logic [TreeW-1:0] tree_touch(input logic [TreeW-1:0] t,
                                                    input logic [s_way-1:0] w);
        logic [TreeW-1:0] r;
        int               node;
        logic             dir;
        r    = t;
        node = 0;
        for (int l = 0; l < int'(s_way); l++) begin
            dir = w[int'(s_way) - 1 - l];
            for (int n = 0; n < int'(TreeW); n++) begin
                if (node == n) r[n] = ~dir;
            end
            node = 2 * node + 1 + int'(dir);
        end
        return r;
    endfunction

    // Follow the tree bits from the root; first decision lands in the victim MSB.
    function automatic logic [s_way-1:0] tree_victim(input logic [TreeW-1:0] t);
        logic [s_way-1:0] v;
        int               node;
        logic             dir;
        v    = '0;
        node = 0;
        for (int l = 0; l < int'(s_way); l++) begin
            dir = 1'b0;
            for (int n = 0; n < int'(TreeW); n++) begin
                if (node == n) dir = t[n];
            end
            v[int'(s_way) - 1 - l] = dir;
            node = 2 * node + 1 + int'(dir);
        end
        return v;
    endfunction

    assign busy     = (state_q == StClear);
    assign touch_en = touch && !busy;

    always_comb begin
        wr_tree = tree_touch(mem_q[windex], tway);
        if (BYPASS && touch_en && (windex == rindex)) begin
            rd_tree = wr_tree;
        end else begin
            rd_tree = mem_q[rindex];
        end
        plru_out = rd_tree;
        victim   = tree_victim(rd_tree);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (clear_req) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A touch in the same edge as clear_req (IDLE) still lands; the sweep clears it later.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NumSets); i++) mem_q[i] <= '0;
        end else if (busy) begin
            mem_q[cnt_q] <= '0;
        end else if (touch_en) begin
            mem_q[windex] <= wr_tree;
        end
    end

endmodule

// File: tb/tb_plru_array.sv
// Directed bench for plru_array (8 sets, 4 ways); a BYPASS=1 and a BYPASS=0 instance share stimulus.
module tb_plru_array;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] rindex;
    logic [2:0] windex;
    logic [1:0] tway;
    logic       touch;
    logic       clear_req;
    logic [1:0] victim, victim_nb;
    logic [2:0] plru, plru_nb;
    logic       busy, busy_nb;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    plru_array #(.s_index(3), .s_way(2), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .rindex(rindex), .victim(victim), .plru_out(plru),
        .touch(touch), .windex(windex), .tway(tway), .clear_req(clear_req), .busy(busy)
    );

    plru_array #(.s_index(3), .s_way(2), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .rindex(rindex), .victim(victim_nb), .plru_out(plru_nb),
        .touch(touch), .windex(windex), .tway(tway), .clear_req(clear_req), .busy(busy_nb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_touch(input logic [2:0] idx, input logic [1:0] way);
        touch  = 1'b1;
        windex = idx;
        tway   = way;
        tick();
        touch  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            rindex = 3'(i);
            #1;
            n_cmp++;
            if (victim !== 2'd0 || plru !== 3'b000) begin
                n_fail++;
                $display("FAIL reset set %0d: victim=%0d plru=%b, want 0/000", i, victim, plru);
            end
            n_cmp++;
            if (victim_nb !== 2'd0 || plru_nb !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_nb set %0d: victim=%0d plru=%b, want 0/000",
                         i, victim_nb, plru_nb);
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset busy: got %b want 0", busy);
        end
    endtask

    task automatic test_touch_seq();
        do_reset();
        rindex = 3'd2;
        do_touch(3'd2, 2'd0);
        n_cmp++;
        if (plru !== 3'b011 || victim !== 2'd2) begin
            n_fail++;
            $display("FAIL touch_w0: plru=%b victim=%0d, want 011/2", plru, victim);
        end
        do_touch(3'd2, 2'd2);
        n_cmp++;
        if (plru !== 3'b110 || victim !== 2'd1) begin
            n_fail++;
            $display("FAIL touch_w2: plru=%b victim=%0d, want 110/1", plru, victim);
        end
        do_touch(3'd2, 2'd1);
        n_cmp++;
        if (plru !== 3'b101 || victim !== 2'd3) begin
            n_fail++;
            $display("FAIL touch_w1: plru=%b victim=%0d, want 101/3", plru, victim);
        end
        do_touch(3'd2, 2'd3);
        n_cmp++;
        if (plru !== 3'b000 || victim !== 2'd0) begin
            n_fail++;
            $display("FAIL touch_w3: plru=%b victim=%0d, want 000/0", plru, victim);
        end
    endtask

    task automatic test_bypass();
        do_reset();
        rindex = 3'd5;
        windex = 3'd5;
        tway   = 2'd0;
        touch  = 1'b1;
        #1;
        n_cmp++;
        if (victim !== 2'd2) begin
            n_fail++;
            $display("FAIL bypass_same_cycle: victim=%0d want 2", victim);
        end
        n_cmp++;
        if (victim_nb !== 2'd0) begin
            n_fail++;
            $display("FAIL nobypass_same_cycle: victim=%0d want 0", victim_nb);
        end
        tick();
        touch = 1'b0;
        #1;
        n_cmp++;
        if (victim_nb !== 2'd2 || victim !== 2'd2) begin
            n_fail++;
            $display("FAIL bypass_next_cycle: victim=%0d victim_nb=%0d want 2/2",
                     victim, victim_nb);
        end
    endtask

    task automatic test_isolation();
        do_reset();
        rindex = 3'd6;
        do_touch(3'd7, 2'd3);
        n_cmp++;
        if (victim !== 2'd0 || plru !== 3'b000) begin
            n_fail++;
            $display("FAIL iso_set6: victim=%0d plru=%b want 0/000", victim, plru);
        end
        rindex = 3'd7;
        #1;
        n_cmp++;
        if (victim !== 2'd0 || plru !== 3'b000) begin
            n_fail++;
            $display("FAIL iso_set7_w3: victim=%0d plru=%b want 0/000", victim, plru);
        end
        do_touch(3'd7, 2'd0);
        n_cmp++;
        if (plru !== 3'b011) begin
            n_fail++;
            $display("FAIL iso_set7_w0: plru=%b want 011", plru);
        end
        rindex = 3'd6;
        #1;
        n_cmp++;
        if (plru !== 3'b000) begin
            n_fail++;
            $display("FAIL iso_set6_after: plru=%b want 000", plru);
        end
    endtask

    task automatic test_clear_sweep();
        int n;
        do_reset();
        for (int i = 0; i < 8; i++) do_touch(3'(i), 2'd0);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            n++;
            if (n == 2) begin
                rindex = 3'd0;
                #1;
                n_cmp++;
                if (plru !== 3'b000) begin
                    n_fail++;
                    $display("FAIL sweep_cleared_set0: plru=%b want 000", plru);
                end
                rindex = 3'd7;
                #1;
                n_cmp++;
                if (plru !== 3'b011) begin
                    n_fail++;
                    $display("FAIL sweep_pending_set7: plru=%b want 011", plru);
                end
                rindex    = 3'd4;
                windex    = 3'd4;
                tway      = 2'd3;
                touch     = 1'b1;
                clear_req = 1'b1;
                #1;
                n_cmp++;
                if (victim !== 2'd2) begin
                    n_fail++;
                    $display("FAIL busy_touch_bypass: victim=%0d want 2", victim);
                end
            end
            tick();
            touch     = 1'b0;
            clear_req = 1'b0;
            if (n == 2) begin
                #1;
                n_cmp++;
                if (plru !== 3'b011) begin
                    n_fail++;
                    $display("FAIL busy_touch_ignored: plru=%b want 011", plru);
                end
            end
        end
        n_cmp++;
        if (n != 8) begin
            n_fail++;
            $display("FAIL sweep_len: busy cycles=%0d want 8", n);
        end
        for (int i = 0; i < 8; i++) begin
            rindex = 3'(i);
            #1;
            n_cmp++;
            if (victim !== 2'd0 || plru !== 3'b000) begin
                n_fail++;
                $display("FAIL after_sweep set %0d: victim=%0d plru=%b want 0/000",
                         i, victim, plru);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        for (int i = 0; i < 8; i++) do_touch(3'(i), 2'd0);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        tick();
        tick();
        do_reset();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid busy: got %b want 0", busy);
        end
        for (int i = 0; i < 8; i++) begin
            rindex = 3'(i);
            #1;
            n_cmp++;
            if (plru !== 3'b000) begin
                n_fail++;
                $display("FAIL rst_mid set %0d: plru=%b want 000", i, plru);
            end
        end
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        n_cmp++;
        if (n != 8) begin
            n_fail++;
            $display("FAIL rst_mid resweep_len: busy cycles=%0d want 8", n);
        end
    endtask

    initial begin
        rst       = 1'b1;
        rindex    = '0;
        windex    = '0;
        tway      = '0;
        touch     = 1'b0;
        clear_req = 1'b0;
        test_reset();
        test_touch_seq();
        test_bypass();
        test_isolation();
        test_clear_sweep();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
